// File: rtl/ifid_skid_reg.sv
// rtl/ifid_skid_reg.sv - IF/ID pipeline register with one-entry skid buffer, flush and stall counter
module ifid_skid_reg #(
  parameter int                   INSTR_W   = 32,
  parameter int                   PC_W      = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0,
  parameter int                   CNT_W     = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               InValid,
  output logic               InReady,
  input  logic [INSTR_W-1:0] InstructionIn,
  input  logic [PC_W-1:0]    PCAdderIn,
  input  logic               Flush,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [INSTR_W-1:0] InstructionOut,
  output logic [PC_W-1:0]    PCAdderOut,
  output logic [CNT_W-1:0]   StallCount
);

  // Main entry drives decode; skid entry catches the beat that arrives while main is stalled.
  logic               main_valid;
  logic [INSTR_W-1:0] main_instr;
  logic [PC_W-1:0]    main_pc;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;

  logic accept;
  logic consume;
  logic main_free;
  logic stall;
  logic stall_sat;

  // Handshake terms; InReady depends only on the skid flag and Reset, never on OutReady.
  always_comb begin
    InReady   = ~skid_valid & ~Reset;
    accept    = InValid & InReady;
    consume   = main_valid & OutReady;
    main_free = ~main_valid | consume;
    stall     = main_valid & ~OutReady;
    stall_sat = &StallCount;
  end

  // Main register: refill from skid first (older beat), then from the input, else go empty.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      main_valid <= 1'b0;
      main_instr <= NOP_INSTR;
      main_pc    <= '0;
    end else if (Flush) begin
      main_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_instr <= skid_instr;
        main_pc    <= skid_pc;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_instr <= InstructionIn;
        main_pc    <= PCAdderIn;
      end else begin
        main_valid <= 1'b0;
      end
    end
  end

  // Skid register: captures an accepted beat when main is held, refills when it drains.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      skid_valid <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= '0;
    end else if (Flush) begin
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        skid_valid <= accept;
        if (accept) begin
          skid_instr <= InstructionIn;
          skid_pc    <= PCAdderIn;
        end
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_instr <= InstructionIn;
      skid_pc    <= PCAdderIn;
    end
  end

  // Saturating count of cycles where decode holds off a valid beat; Flush leaves it alone.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCount <= '0;
    end else if (stall && !stall_sat) begin
      StallCount <= StallCount + 1'b1;
    end
  end

  // Bubble outputs whenever the main entry is empty.
  always_comb begin
    OutValid       = main_valid;
    InstructionOut = main_valid ? main_instr : NOP_INSTR;
    PCAdderOut     = main_valid ? main_pc : '0;
  end

endmodule

// File: tb/tb_ifid_skid_reg.sv
// tb/tb_ifid_skid_reg.sv - randomized and directed bench for ifid_skid_reg against a queue model
module tb_ifid_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        Clk = 1'b0;
  logic        Reset, InValid, Flush, OutReady;
  logic [31:0] InstructionIn, PCAdderIn;
  logic        InReady, OutValid;
  logic [31:0] InstructionOut, PCAdderOut;
  logic [15:0] StallCount;
  logic        InReady4, OutValid4;
  logic [31:0] InstructionOut4, PCAdderOut4;
  logic [3:0]  StallCount4;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed { logic [31:0] i; logic [31:0] p; } beat_t;
  beat_t       mq[$];
  int unsigned mstall, mstall4;

  always #5 Clk = ~Clk;

  ifid_skid_reg #(.INSTR_W(32), .PC_W(32), .NOP_INSTR(NOP), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InstructionIn(InstructionIn), .PCAdderIn(PCAdderIn), .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady), .InstructionOut(InstructionOut),
    .PCAdderOut(PCAdderOut), .StallCount(StallCount)
  );

  ifid_skid_reg #(.INSTR_W(32), .PC_W(32), .NOP_INSTR(NOP), .CNT_W(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady4),
    .InstructionIn(InstructionIn), .PCAdderIn(PCAdderIn), .Flush(Flush),
    .OutValid(OutValid4), .OutReady(OutReady), .InstructionOut(InstructionOut4),
    .PCAdderOut(PCAdderOut4), .StallCount(StallCount4)
  );

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic r, input logic f, input logic rst);
    InValid = v; InstructionIn = ins; PCAdderIn = pc;
    OutReady = r; Flush = f; Reset = rst;
  endtask

  // Advance one edge and apply the same edge to the reference queue.
  task automatic tick();
    bit acc;
    @(posedge Clk);
    if (Reset) begin
      mq.delete();
      mstall = 0;
      mstall4 = 0;
    end else begin
      acc = InValid && (mq.size() < 2);
      if (mq.size() > 0 && !OutReady) begin
        if (mstall < 65535) mstall++;
        if (mstall4 < 15) mstall4++;
      end
      if (Flush) mq.delete();
      else begin
        if (mq.size() > 0 && OutReady) void'(mq.pop_front());
        if (acc) mq.push_back('{i: InstructionIn, p: PCAdderIn});
      end
    end
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 1);
    tick();
    tick();
    #1;
    n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL reset_outvalid got %b want 0", OutValid); end
    n_cmp++; if (InReady !== 1'b0) begin n_bad++; $display("FAIL reset_inready got %b want 0", InReady); end
    n_cmp++; if (InstructionOut !== NOP) begin n_bad++; $display("FAIL reset_instr got %h want %h", InstructionOut, NOP); end
    n_cmp++; if (PCAdderOut !== 32'h0) begin n_bad++; $display("FAIL reset_pc got %h want 0", PCAdderOut); end
    n_cmp++; if (StallCount !== 16'h0) begin n_bad++; $display("FAIL reset_stall got %0d want 0", StallCount); end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL reset_release_inready got %b want 1", InReady); end
  endtask

  task automatic test_streaming();
    logic [31:0] ins;
    do_reset();
    for (int k = 0; k <= 4; k++) begin
      ins = 32'h2008_0005 + k;
      drive(k < 4, ins, 32'(4 * (k + 1)), 1, 0, 0);
      #1;
      if (k > 0) begin
        n_cmp++; if (OutValid !== 1'b1 || InstructionOut !== ins - 1 || PCAdderOut !== 32'(4 * k)) begin
          n_bad++; $display("FAIL stream_beat%0d got v=%b %h/%h want 1 %h/%h", k - 1, OutValid, InstructionOut, PCAdderOut, ins - 1, 4 * k);
        end
      end
      n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL stream_inready%0d got %b want 1", k, InReady); end
      tick();
    end
    n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL stream_drain got %b want 0", OutValid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1, 32'hAAAA_0001, 32'h100, 0, 0, 0); tick();
    drive(1, 32'hAAAA_0002, 32'h104, 0, 0, 0); #1;
    n_cmp++; if (OutValid !== 1'b1 || InstructionOut !== 32'hAAAA_0001) begin n_bad++; $display("FAIL bp_hold0 got %b %h want 1 aaaa0001", OutValid, InstructionOut); end
    tick();
    drive(0, 0, 0, 0, 0, 0); #1;
    n_cmp++; if (InReady !== 1'b0) begin n_bad++; $display("FAIL bp_inready got %b want 0", InReady); end
    n_cmp++; if (InstructionOut !== 32'hAAAA_0001 || PCAdderOut !== 32'h100) begin n_bad++; $display("FAIL bp_hold1 got %h/%h want aaaa0001/100", InstructionOut, PCAdderOut); end
    tick();
    drive(0, 0, 0, 1, 0, 0); #1;
    n_cmp++; if (StallCount !== 16'd2) begin n_bad++; $display("FAIL bp_stallcount got %0d want 2", StallCount); end
    n_cmp++; if (OutValid !== 1'b1 || InstructionOut !== 32'hAAAA_0001) begin n_bad++; $display("FAIL bp_deliver0 got %b %h want 1 aaaa0001", OutValid, InstructionOut); end
    tick(); #1;
    n_cmp++; if (OutValid !== 1'b1 || InstructionOut !== 32'hAAAA_0002 || PCAdderOut !== 32'h104) begin n_bad++; $display("FAIL bp_deliver1 got %b %h/%h want 1 aaaa0002/104", OutValid, InstructionOut, PCAdderOut); end
    n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL bp_inready_after got %b want 1", InReady); end
    tick(); #1;
    n_cmp++; if (OutValid !== 1'b0 || StallCount !== 16'd2) begin n_bad++; $display("FAIL bp_end got v=%b cnt=%0d want 0 2", OutValid, StallCount); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 32'hBBBB_0001, 32'h200, 0, 0, 0); tick();
    drive(1, 32'hBBBB_0002, 32'h204, 0, 0, 0); tick();
    drive(1, 32'hBBBB_0003, 32'h208, 0, 1, 0); tick();
    for (int c = 0; c < 4; c++) begin
      drive(c == 0, 32'hCCCC_0000, 32'h300, 1, 0, 0); #1;
      if (c == 0) begin
        n_cmp++; if (OutValid !== 1'b0 || InstructionOut !== NOP || PCAdderOut !== 32'h0) begin
          n_bad++; $display("FAIL flush_bubble got v=%b %h/%h want 0 %h/0", OutValid, InstructionOut, PCAdderOut, NOP);
        end
        n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL flush_inready got %b want 1", InReady); end
      end else begin
        n_cmp++; if (InstructionOut[31:16] === 16'hBBBB) begin n_bad++; $display("FAIL flush_leak got %h want none of bbbb000x", InstructionOut); end
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 32'hDDDD_0001, 32'h400, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 20; c++) tick();
    n_cmp++; if (StallCount4 !== 4'hF) begin n_bad++; $display("FAIL sat_cnt4 got %h want f", StallCount4); end
    n_cmp++; if (StallCount !== 16'd20) begin n_bad++; $display("FAIL sat_cnt16 got %0d want 20", StallCount); end
    for (int c = 0; c < 3; c++) tick();
    n_cmp++; if (StallCount4 !== 4'hF) begin n_bad++; $display("FAIL sat_hold got %h want f", StallCount4); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    drive(1, 32'hEEEE_0001, 32'h500, 0, 0, 0); tick();
    drive(1, 32'hEEEE_0002, 32'h504, 0, 0, 0); tick();
    drive(1, 32'hEEEE_0003, 32'h508, 1, 1, 1); #1;
    n_cmp++; if (InReady !== 1'b0) begin n_bad++; $display("FAIL rstmid_inready got %b want 0", InReady); end
    tick();
    drive(0, 0, 0, 1, 0, 0); #1;
    n_cmp++; if (OutValid !== 1'b0 || InstructionOut !== NOP || PCAdderOut !== 32'h0 || StallCount !== 16'h0) begin
      n_bad++; $display("FAIL rstmid_outs got v=%b %h/%h cnt=%0d want 0 %h/0 0", OutValid, InstructionOut, PCAdderOut, StallCount, NOP);
    end
    n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL rstmid_inready_after got %b want 1", InReady); end
    drive(1, 32'hEEEE_0009, 32'h520, 1, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 0); #1;
    n_cmp++; if (OutValid !== 1'b1 || InstructionOut !== 32'hEEEE_0009 || PCAdderOut !== 32'h520) begin
      n_bad++; $display("FAIL rstmid_newbeat got v=%b %h/%h want 1 eeee0009/520", OutValid, InstructionOut, PCAdderOut);
    end
    tick();
  endtask

  task automatic test_random();
    logic        ev;
    logic [31:0] ei, ep;
    logic        er;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      drive($urandom_range(99) < 70, $urandom, $urandom, $urandom_range(99) < 60,
            $urandom_range(99) < 4, $urandom_range(999) < 5);
      #1;
      ev = (mq.size() > 0);
      ei = ev ? mq[0].i : NOP;
      ep = ev ? mq[0].p : 32'h0;
      er = (mq.size() < 2) && !Reset;
      n_cmp++; if (OutValid !== ev || InstructionOut !== ei || PCAdderOut !== ep) begin
        n_bad++; $display("FAIL rand_out cyc%0d got %b %h/%h want %b %h/%h", c, OutValid, InstructionOut, PCAdderOut, ev, ei, ep);
      end
      n_cmp++; if (InReady !== er) begin n_bad++; $display("FAIL rand_inready cyc%0d got %b want %b", c, InReady, er); end
      n_cmp++; if (StallCount !== 16'(mstall)) begin n_bad++; $display("FAIL rand_stall cyc%0d got %0d want %0d", c, StallCount, mstall); end
      n_cmp++; if (OutValid4 !== ev || InstructionOut4 !== ei || PCAdderOut4 !== ep || InReady4 !== er || StallCount4 !== 4'(mstall4)) begin
        n_bad++; $display("FAIL rand_dut4 cyc%0d got %b %h/%h %b %0d want %b %h/%h %b %0d", c, OutValid4, InstructionOut4, PCAdderOut4, InReady4, StallCount4, ev, ei, ep, er, mstall4);
      end
      tick();
    end
  endtask

  initial begin
    mstall = 0;
    mstall4 = 0;
    drive(0, 0, 0, 0, 0, 1);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifid_skid_reg.md
IFID_SKID_REG -- requirements
Module: ifid_skid_reg

Interface
REQ-001 SHALL have parameter INSTR_W, default 32: instruction field width in bits.
REQ-002 SHALL have parameter PC_W, default 32: PC+4 field width in bits.
REQ-003 SHALL have parameter NOP_INSTR, default 0 (INSTR_W bits): value driven on InstructionOut when the stage holds no valid beat.
REQ-004 SHALL have parameter CNT_W, default 16: width of the stall counter.
REQ-005 SHALL have port Clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port InValid, input, 1 bit: the fetch stage presents a beat.
REQ-008 SHALL have port InReady, output, 1 bit: the stage accepts a beat this cycle.
REQ-009 SHALL have port InstructionIn, input, INSTR_W bits: fetched instruction.
REQ-010 SHALL have port PCAdderIn, input, PC_W bits: PC+4 of the fetched instruction.
REQ-011 SHALL have port Flush, input, 1 bit: discard all held and incoming beats (branch taken or jump).
REQ-012 SHALL have port OutValid, output, 1 bit: InstructionOut and PCAdderOut hold a valid beat.
REQ-013 SHALL have port OutReady, input, 1 bit: the decode stage consumes the beat this cycle.
REQ-014 SHALL have port InstructionOut, output, INSTR_W bits: registered instruction to decode.
REQ-015 SHALL have port PCAdderOut, output, PC_W bits: registered PC+4 to decode.
REQ-016 SHALL have port StallCount, output, CNT_W bits: saturating count of decode-stall cycles.

Function
REQ-017 SHALL hold two entries: a main output register (drives the Out* ports) and one skid register; each has its own valid bit.
REQ-018 SHALL accept an input beat when InValid=1 and InReady=1, and deliver an output beat when OutValid=1 and OutReady=1.
REQ-019 SHALL drive InReady = NOT skid_valid AND NOT Reset; InReady is a register-derived signal with no combinational path from OutReady.
REQ-020 SHALL have a latency of exactly 1 cycle from acceptance to OutValid when the main register is empty or being consumed that cycle.
REQ-021 SHALL refill the main register, when it is empty or consumed, from the skid register if skid_valid=1, otherwise from the accepted input beat, otherwise mark it invalid.
REQ-022 SHALL write an accepted beat into the skid register when the main register is valid and not consumed that cycle.
REQ-023 SHALL, when the skid drains into main and a new beat is accepted in the same cycle, refill the skid with the new beat; throughput is 1 beat per cycle with strict FIFO order and no loss or duplication.
REQ-024 SHALL hold InstructionOut and PCAdderOut stable while OutValid=1 and OutReady=0.
REQ-025 SHALL drive InstructionOut = NOP_INSTR and PCAdderOut = 0 whenever OutValid=0 (bubble).
REQ-026 SHALL, on Flush=1, clear both valid bits on the next edge and drop any beat accepted in the same cycle; Flush takes priority over every load; InReady stays as defined in REQ-019.
REQ-027 SHALL increment StallCount on each cycle with OutValid=1 and OutReady=0 and saturate at all-ones (no wrap); a Flush does not change StallCount.

Reset
REQ-028 SHALL, while Reset=1 at a rising edge, clear both valid bits, set InstructionOut=NOP_INSTR, PCAdderOut=0, OutValid=0 and StallCount=0; Reset overrides Flush and all loads.
REQ-029 SHALL hold InReady=0 while Reset=1, and set InReady=1 in the first cycle after Reset deasserts.
REQ-030 SHALL, when Reset is asserted mid-stream, discard both held beats with no partial output.

Verification
REQ-031 Streaming check: OutReady=1, beats I0..I3 (e.g. 0x20080005, PC 0x4, 0x8, ...) on consecutive cycles -> each appears one cycle later, OutValid continuous, InReady=1 throughout.
REQ-032 Backpressure check: OutReady=0 while I0 and I1 arrive -> I0 is held on the outputs, I1 goes to the skid, InReady=0; OutReady=1 -> I0 then I1 are delivered on consecutive cycles, and StallCount equals the number of stalled cycles.
REQ-033 Flush check: Flush=1 with both entries full and InValid=1 -> next cycle OutValid=0, InstructionOut=NOP_INSTR, PCAdderOut=0, InReady=1; none of the three beats ever appears.
REQ-034 Saturation check: CNT_W=4 with 20 stall cycles -> StallCount=0xF and holds there.
REQ-035 Reset check: Reset pulsed while holding two beats -> all outputs at reset values, InReady=0 during the pulse and 1 the cycle after; a new beat then passes with 1-cycle latency.
REQ-036 Random check: random InValid/OutReady/Flush for 10k cycles against a scoreboard -> order preserved, no loss outside flushes, outputs stable under stall.
